// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: prefix FSM, make-code lookup and 4-entry symbol FIFO.
// Optional typematic repeat filter enabled by defining PS2_REPEAT_FILTER_EN.
module ps2_scancode_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_received_data,
  input  logic       ps2_received_data_strb,
  output logic [5:0] sym_data,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       fifo_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXT       = 2'd1,
    ST_BREAK     = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_t;

  // Returns {hit, symbol}; hit=0 for codes with no symbol assigned.
  function automatic logic [6:0] lookup(input logic [7:0] code);
    case (code)
      8'h1C: lookup = {1'b1, 6'd0};   8'h32: lookup = {1'b1, 6'd1};
      8'h21: lookup = {1'b1, 6'd2};   8'h23: lookup = {1'b1, 6'd3};
      8'h24: lookup = {1'b1, 6'd4};   8'h2B: lookup = {1'b1, 6'd5};
      8'h34: lookup = {1'b1, 6'd6};   8'h33: lookup = {1'b1, 6'd7};
      8'h43: lookup = {1'b1, 6'd8};   8'h3B: lookup = {1'b1, 6'd9};
      8'h42: lookup = {1'b1, 6'd10};  8'h4B: lookup = {1'b1, 6'd11};
      8'h3A: lookup = {1'b1, 6'd12};  8'h31: lookup = {1'b1, 6'd13};
      8'h44: lookup = {1'b1, 6'd14};  8'h4D: lookup = {1'b1, 6'd15};
      8'h15: lookup = {1'b1, 6'd16};  8'h2D: lookup = {1'b1, 6'd17};
      8'h1B: lookup = {1'b1, 6'd18};  8'h2C: lookup = {1'b1, 6'd19};
      8'h3C: lookup = {1'b1, 6'd20};  8'h2A: lookup = {1'b1, 6'd21};
      8'h1D: lookup = {1'b1, 6'd22};  8'h22: lookup = {1'b1, 6'd23};
      8'h35: lookup = {1'b1, 6'd24};  8'h1A: lookup = {1'b1, 6'd25};
      8'h45: lookup = {1'b1, 6'd26};  8'h16: lookup = {1'b1, 6'd27};
      8'h1E: lookup = {1'b1, 6'd28};  8'h26: lookup = {1'b1, 6'd29};
      8'h25: lookup = {1'b1, 6'd30};  8'h2E: lookup = {1'b1, 6'd31};
      8'h36: lookup = {1'b1, 6'd32};  8'h3D: lookup = {1'b1, 6'd33};
      8'h3E: lookup = {1'b1, 6'd34};  8'h46: lookup = {1'b1, 6'd35};
      8'h29: lookup = {1'b1, 6'd36};  8'h5A: lookup = {1'b1, 6'd37};
      default: lookup = 7'd0;
    endcase
  endfunction

  state_t      state_r, state_s;
  logic [6:0]  lookup_s;
  logic        push_s, push_r;
  logic [5:0]  push_data_r;
  logic        held_set_s, held_clr_s;
  logic [5:0]  held_r;
  logic        held_valid_r;
  logic [5:0]  mem_r [4];
  logic [1:0]  wr_ptr_r, rd_ptr_r;
  logic [2:0]  count_r, count_s;
  logic        sym_valid_r, overflow_r;
  logic        pop_s, write_s, overflow_s;

  assign lookup_s = lookup(ps2_received_data);

  // Prefix FSM: decides next state and whether this byte yields a symbol.
  always_comb begin
    state_s    = state_r;
    push_s     = 1'b0;
    held_set_s = 1'b0;
    held_clr_s = 1'b0;
    if (ps2_received_data_strb) begin
      case (state_r)
        ST_IDLE: begin
          if (ps2_received_data == 8'hE0) begin
            state_s = ST_EXT;
          end else if (ps2_received_data == 8'hF0) begin
            state_s = ST_BREAK;
          end else if (lookup_s[6]) begin
`ifdef PS2_REPEAT_FILTER_EN
            if (held_valid_r && (held_r == lookup_s[5:0])) begin
              push_s = 1'b0;
            end else begin
              push_s     = 1'b1;
              held_set_s = 1'b1;
            end
`else
            push_s = 1'b1;
`endif
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (ps2_received_data == 8'hF0) begin
            state_s = ST_EXT_BREAK;
          end else if (ps2_received_data == 8'hE0) begin
            state_s = ST_EXT;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_BREAK: begin
          state_s = ST_IDLE;
          if (lookup_s[6] && held_valid_r && (held_r == lookup_s[5:0])) begin
            held_clr_s = 1'b1;
          end else begin
            held_clr_s = 1'b0;
          end
        end
        ST_EXT_BREAK: state_s = ST_IDLE;
        default:      state_s = ST_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM state and the one-cycle write stage in front of the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      push_r      <= 1'b0;
      push_data_r <= 6'd0;
    end else begin
      state_r     <= state_s;
      push_r      <= push_s;
      push_data_r <= lookup_s[5:0];
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  // Held key for typematic repeat suppression.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_r       <= 6'd0;
      held_valid_r <= 1'b0;
    end else if (held_set_s) begin
      held_r       <= lookup_s[5:0];
      held_valid_r <= 1'b1;
    end else if (held_clr_s) begin
      held_valid_r <= 1'b0;
    end else begin
      held_valid_r <= held_valid_r;
    end
  end
`else
  assign held_r       = 6'd0;
  assign held_valid_r = 1'b0;
`endif

  // FIFO control: a pop frees a slot so a push into a full FIFO still lands.
  always_comb begin
    pop_s      = (count_r != 3'd0) && sym_ready;
    write_s    = push_r && ((count_r != 3'd4) || pop_s);
    overflow_s = push_r && (count_r == 3'd4) && !pop_s;
    count_s    = count_r + {2'd0, write_s} - {2'd0, pop_s};
  end

  // FIFO storage, pointers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem_r[i] <= 6'd0;
      wr_ptr_r    <= 2'd0;
      rd_ptr_r    <= 2'd0;
      count_r     <= 3'd0;
      sym_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (write_s) begin
        mem_r[wr_ptr_r] <= push_data_r;
        wr_ptr_r        <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      count_r     <= count_s;
      sym_valid_r <= (count_s != 3'd0);
      overflow_r  <= overflow_s;
    end
  end

  assign sym_data      = mem_r[rd_ptr_r];
  assign sym_valid     = sym_valid_r;
  assign fifo_overflow = overflow_r;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: expected symbols queued at stimulus time,
// compared as the consumer accepts them.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_received_data;
  logic       ps2_received_data_strb;
  logic [5:0] sym_data;
  logic       sym_valid;
  logic       sym_ready;
  logic       fifo_overflow;

  int tests_run = 0;
  int tests_failed = 0;
  int ovf_cnt = 0;
  int ovf_base;
  logic [5:0] exp_q[$];

  localparam logic [7:0] KEYS [38] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h45, 8'h16, 8'h1E, 8'h26,
    8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h29, 8'h5A};

  ps2_scancode_decoder dut (
    .clk                    (clk),
    .rst                    (rst),
    .ps2_received_data      (ps2_received_data),
    .ps2_received_data_strb (ps2_received_data_strb),
    .sym_data               (sym_data),
    .sym_valid              (sym_valid),
    .sym_ready              (sym_ready),
    .fifo_overflow          (fifo_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (fifo_overflow) ovf_cnt++;
        if (sym_valid && sym_ready) begin
          if (exp_q.size() == 0) check("unexpected_sym", int'(sym_data), 255);
          else check("sym", int'(sym_data), int'(exp_q.pop_front()));
        end
      end
    end
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Caller is just after a rising edge; leaves the bench one cycle later.
  task automatic strobe(input logic [7:0] b);
    ps2_received_data      = b;
    ps2_received_data_strb = 1'b1;
    sync();
    ps2_received_data_strb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  task automatic do_reset();
    sync();
    rst = 1'b1;
    ps2_received_data_strb = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    idle(3);
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !sym_valid) break;
      sync();
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ps2_received_data = 8'h00;
    ps2_received_data_strb = 1'b0;
    sym_ready = 1'b1;
    fork monitor(); join_none
    idle(3);
    @(negedge clk);
    check("rst_valid", int'(sym_valid), 0);
    check("rst_data", int'(sym_data), 0);
    check("rst_ovf", int'(fifo_overflow), 0);

    // Single make code: two-cycle latency, accepted immediately.
    do_reset();
    exp_q.push_back(6'd0);
    strobe(8'h1C);
    @(negedge clk); check("lat_c1", int'(sym_valid), 0);
    @(negedge clk); check("lat_c2", int'(sym_valid), 1);
    check("lat_data", int'(sym_data), 0);
    @(negedge clk); check("lat_c3", int'(sym_valid), 0);
    wait_drain("lat_drain");

    // Break and extended sequences yield nothing beyond the first make.
    do_reset();
    ovf_base = ovf_cnt;
    exp_q.push_back(6'd0);
    strobe(8'h1C); strobe(8'hF0); strobe(8'h1C); strobe(8'hE0);
    strobe(8'h5A); strobe(8'hE0); strobe(8'hF0); strobe(8'h5A);
    wait_drain("seq_drain");

    // Full key table back-to-back with unmapped codes mixed in.
    do_reset();
    for (int i = 0; i < 38; i++) begin
      exp_q.push_back(6'(i));
      strobe(KEYS[i]);
      if (i % 9 == 4) strobe(8'h76);
    end
    strobe(8'h00);
    wait_drain("map_drain");
    check("map_no_ovf", ovf_cnt - ovf_base, 0);

    // Overflow: fifth byte into a stalled FIFO is dropped.
    do_reset();
    sym_ready = 1'b0;
    ovf_base = ovf_cnt;
    for (int i = 27; i <= 30; i++) exp_q.push_back(6'(i));
    strobe(8'h16); strobe(8'h1E); strobe(8'h26); strobe(8'h25); strobe(8'h2E);
    idle(5);
    check("ovf_pulse", ovf_cnt - ovf_base, 1);
    @(negedge clk);
    check("ovf_valid", int'(sym_valid), 1);
    check("ovf_head", int'(sym_data), 27);
    sync();
    sym_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_once", ovf_cnt - ovf_base, 1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    sym_ready = 1'b0;
    ovf_base = ovf_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back(6'(i));
    strobe(8'h1C); strobe(8'h32); strobe(8'h21); strobe(8'h23);
    idle(4);
    strobe(8'h24);
    sym_ready = 1'b1;
    sync();
    sym_ready = 1'b0;
    idle(3);
    @(negedge clk);
    check("pp_valid", int'(sym_valid), 1);
    check("pp_head", int'(sym_data), 1);
    check("pp_no_ovf", ovf_cnt - ovf_base, 0);
    sync();
    sym_ready = 1'b1;
    wait_drain("pp_drain");
    check("pp_order_ovf", ovf_cnt - ovf_base, 0);

    // Typematic repeats.
    do_reset();
`ifdef PS2_REPEAT_FILTER_EN
    repeat (2) exp_q.push_back(6'd0);
`else
    repeat (4) exp_q.push_back(6'd0);
`endif
    strobe(8'h1C); strobe(8'h1C); strobe(8'h1C);
    strobe(8'hF0); strobe(8'h1C); strobe(8'h1C);
    wait_drain("rep_drain");

    // Reset between F0 and the next make discards the prefix; strobe in reset ignored.
    do_reset();
    strobe(8'hF0);
    rst = 1'b1;
    ps2_received_data = 8'h1C;
    ps2_received_data_strb = 1'b1;
    sync();
    rst = 1'b0;
    ps2_received_data_strb = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", int'(sym_valid), 0);
    sync();
    exp_q.push_back(6'd36);
    strobe(8'h29);
    wait_drain("mid_rst_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: ps2_received_data  input  8  scancode byte from PS/2 receiver.
REQ-004 SHALL have port: ps2_received_data_strb  input  1  one-cycle pulse; byte valid this cycle.
REQ-005 SHALL have port: sym_data  output  6  symbol code at FIFO head.
REQ-006 SHALL have port: sym_valid  output  1  FIFO non-empty.
REQ-007 SHALL have port: sym_ready  input  1  consumer accepts head when sym_valid && sym_ready.
REQ-008 SHALL have port: fifo_overflow  output  1  one-cycle pulse when a symbol is dropped because the FIFO is full.

Function
REQ-009 SHALL decode PS/2 set-2 bytes with FSM states IDLE, EXT (after E0), BREAK (after F0), EXT_BREAK (after E0 F0); it SHALL evaluate only on cycles where strobe=1.
REQ-010 IDLE: byte E0 -> EXT; F0 -> BREAK; any other byte is a make code -> lookup, stay IDLE.
REQ-011 EXT: F0 -> EXT_BREAK; E0 -> stay EXT; other byte -> discard (no extended key is mapped), go IDLE.
REQ-012 BREAK and EXT_BREAK: any byte -> discard, go IDLE.
REQ-013 Lookup SHALL map A..Z = 0..25 from 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A.
REQ-014 Lookup SHALL map 0..9 = 26..35 from 45,16,1E,26,25,2E,36,3D,3E,46; space 29 = 36; enter 5A = 37.
REQ-015 Unmapped make codes SHALL be discarded silently without changing FIFO or fifo_overflow.
REQ-016 A mapped make code SHALL be written to the FIFO on the cycle after its strobe; sym_valid SHALL rise in the cycle following that write, giving 2 cycles strobe-to-sym_valid when the FIFO was empty.
REQ-017 The FIFO SHALL be 4 entries deep, first-in first-out, with 2-bit wrapping read/write pointers and a 3-bit count in the range 0..4.
REQ-018 sym_data SHALL be the head entry whenever sym_valid=1, held stable until accepted; sym_data is don't-care when sym_valid=0.
REQ-019 A write arriving with count=4 and no pop in the same cycle SHALL be dropped and SHALL pulse fifo_overflow for one cycle.
REQ-020 Simultaneous push and pop SHALL both succeed, count unchanged; this SHALL include the count=4 case, with no overflow.
REQ-021 A pop with count=0 SHALL be ignored.
REQ-022 Bytes arriving while strobes occur back-to-back on consecutive cycles SHALL each be processed.

Reset
REQ-023 On rst=1, the FSM SHALL go to IDLE, pointers and count SHALL clear to 0, and outputs SHALL be sym_valid=0, sym_data=0, fifo_overflow=0.
REQ-024 Reset mid-sequence SHALL discard any pending E0/F0 prefix and all FIFO contents; a strobe in the reset cycle SHALL be ignored.

Configuration
REQ-025 Macro PS2_REPEAT_FILTER_EN, when defined, SHALL add a 6-bit held-key register plus a valid bit, cleared at reset.
REQ-026 With PS2_REPEAT_FILTER_EN defined, a make code equal to the held key SHALL be discarded as typematic repeat; a new mapped make SHALL be pushed and become the held key; a break of the held key SHALL clear it.
REQ-027 Without PS2_REPEAT_FILTER_EN, every mapped make code SHALL be pushed, including repeats.

Verification
REQ-028 Reset, then strobe 1C with sym_ready=1 -> sym_valid high for 1 cycle, 2 cycles after the strobe, with sym_data=0.
REQ-029 Sequence 1C, F0, 1C, E0, 5A, E0, F0, 5A -> exactly one symbol (0) is output; the E0 5A pair produces no symbol.
REQ-030 With sym_ready=0, strobe 16,1E,26,25,2E -> FIFO holds 27,28,29,30; fifo_overflow pulses once on the fifth byte; releasing sym_ready drains 27,28,29,30 in order.
REQ-031 With the FIFO full, a push and a pop in the same cycle -> count stays 4 and no overflow pulse.
REQ-032 With PS2_REPEAT_FILTER_EN, strobe 1C,1C,1C,F0,1C,1C -> two 0 symbols are output; without the macro -> four 0 symbols.
REQ-033 Strobe F0 and then assert rst, then strobe 29 -> one symbol 36 (the F0 prefix is not applied to 29).
